// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_if: one request/response bus channel; arbiter masters attach as slave, memory side as master
interface core_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic            ren;
  logic            wen;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] bytemask;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  modport master (output ren, wen, addr, wdata, bytemask, input gnt, rvalid, rdata);
  modport slave (input ren, wen, addr, wdata, bytemask, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin ifetch (m0) / memory-stage (m1) arbiter with one outstanding read.
// Define CORE_ARB_PERF_EN to build the conflict counter; otherwise perf_conflicts_o is tied to 0.
module core_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  core_bus_arbiter_if.slave   m0,
  core_bus_arbiter_if.slave   m1,
  core_bus_arbiter_if.master  mem,
  output logic [31:0]         perf_conflicts_o
);
  logic req0, req1, blocked, sel_vld, sel_id, go, gnt, sel_ren, sel_wen;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_bm;
  logic rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
  logic last_gnt_q, last_gnt_d, hold_vld_q, hold_vld_d, hold_id_q, hold_id_d;
  always_comb begin
    req0       = m0.ren | m0.wen;
    req1       = m1.ren | m1.wen;
    blocked    = rd_pend_q & ~mem.rvalid;
    sel_vld    = rst_n & (hold_vld_q | req0 | req1);
    sel_id     = hold_vld_q ? hold_id_q : (req0 & req1) ? ~last_gnt_q : req1;
    go         = sel_vld & ~blocked;
    gnt        = go & mem.gnt;
    sel_ren    = sel_id ? m1.ren : m0.ren;
    sel_wen    = sel_id ? m1.wen : m0.wen;
    sel_addr   = sel_id ? m1.addr : m0.addr;
    sel_wdata  = sel_id ? m1.wdata : m0.wdata;
    sel_bm     = sel_id ? m1.bytemask : m0.bytemask;
    // a wait state freezes the choice until the memory takes the command
    hold_vld_d = gnt ? 1'b0 : go ? 1'b1 : hold_vld_q;
    hold_id_d  = (go & ~gnt) ? sel_id : hold_id_q;
    last_gnt_d = gnt ? sel_id : last_gnt_q;
    rd_pend_d  = (gnt & sel_ren) ? 1'b1 : mem.rvalid ? 1'b0 : rd_pend_q;
    rd_owner_d = (gnt & sel_ren) ? sel_id : rd_owner_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      last_gnt_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_id_q  <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      last_gnt_q <= last_gnt_d;
      hold_vld_q <= hold_vld_d;
      hold_id_q  <= hold_id_d;
    end
  end
  assign mem.ren      = go & sel_ren;
  assign mem.wen      = go & sel_wen;
  assign mem.addr     = sel_addr;
  assign mem.wdata    = sel_wdata;
  assign mem.bytemask = sel_bm;
  assign m0.gnt       = gnt & ~sel_id;
  assign m1.gnt       = gnt & sel_id;
  assign m0.rvalid    = mem.rvalid & rd_pend_q & ~rd_owner_q;
  assign m1.rvalid    = mem.rvalid & rd_pend_q & rd_owner_q;
  assign m0.rdata     = mem.rdata;
  assign m1.rdata     = mem.rdata;
`ifdef CORE_ARB_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else if (req0 & req1 & ~blocked) perf_q <= perf_q + 32'd1;
  end
  assign perf_conflicts_o = perf_q;
`else
  assign perf_conflicts_o = '0;
`endif
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed checks of grant order, wait-state hold, read blocking and reset
module tb_core_bus_arbiter;
`ifdef CORE_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] perf;
  logic auto_rsp, rsp_q, man_rv;
  int checks = 0;
  int errors = 0;
  core_bus_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  core_bus_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  core_bus_arbiter_if #(.AW(32), .DW(32)) s_if ();
  core_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .mem(s_if), .perf_conflicts_o(perf)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) rsp_q <= s_if.ren & s_if.gnt;
  assign s_if.rvalid = auto_rsp ? rsp_q : man_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; auto_rsp = 1'b1; man_rv = 1'b0; s_if.gnt = 1'b1; s_if.rdata = 32'h0;
    m0_if.ren = 1'b1; m0_if.wen = 1'b0; m0_if.addr = 32'h40; m0_if.wdata = 32'h0; m0_if.bytemask = 4'h0;
    m1_if.ren = 1'b1; m1_if.wen = 1'b0; m1_if.addr = 32'h100; m1_if.wdata = 32'h0; m1_if.bytemask = 4'h0;
    settle();
    chk("rst_s_ren", {31'd0, s_if.ren}, 32'd0);
    chk("rst_s_wen", {31'd0, s_if.wen}, 32'd0);
    chk("rst_m0_gnt", {31'd0, m0_if.gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    chk("rst_perf", perf, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    settle();
    // both request every cycle, auto memory answers reads one cycle later
    for (int i = 0; i < 4; i++) begin
      chk("rr_m1_gnt", {31'd0, m1_if.gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m0_gnt", {31'd0, m0_if.gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) chk("rr_rvalid_owner", {30'd0, m1_if.rvalid, m0_if.rvalid}, (i % 2 == 1) ? 32'd2 : 32'd1);
      cyc();
    end
    m0_if.ren = 1'b0; m1_if.ren = 1'b0;
    settle();
    chk("rr_perf", perf, PERF ? 32'd4 : 32'd0);
    chk("rr_last_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
    cyc();
    auto_rsp = 1'b0;
    // single m1 read
    m1_if.ren = 1'b1; m1_if.addr = 32'h100;
    settle();
    chk("t1_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    chk("t1_s_ren", {31'd0, s_if.ren}, 32'd1);
    chk("t1_s_raddr", s_if.addr, 32'h100);
    cyc();
    m1_if.ren = 1'b0; man_rv = 1'b1; s_if.rdata = 32'hDEADBEEF;
    settle();
    chk("t1_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd1);
    chk("t1_m1_rdata", m1_if.rdata, 32'hDEADBEEF);
    chk("t1_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    cyc();
    man_rv = 1'b0;
    // m1 write, then a stray s_rvalid must reach nobody
    m1_if.wen = 1'b1; m1_if.addr = 32'h200; m1_if.bytemask = 4'h3; m1_if.wdata = 32'h1234;
    settle();
    chk("t5_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    chk("t5_s_wen", {31'd0, s_if.wen}, 32'd1);
    chk("t5_s_ren", {31'd0, s_if.ren}, 32'd0);
    chk("t5_s_waddr", s_if.addr, 32'h200);
    chk("t5_s_bytemask", {28'd0, s_if.bytemask}, 32'h3);
    chk("t5_s_wdata", s_if.wdata, 32'h1234);
    cyc();
    m1_if.wen = 1'b0; man_rv = 1'b1;
    settle();
    chk("t5_no_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    cyc();
    man_rv = 1'b0;
    // m0 read blocks m1 write until the delayed response
    m0_if.ren = 1'b1; m0_if.addr = 32'h44; m1_if.wen = 1'b1; m1_if.addr = 32'h300;
    settle();
    chk("t4_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    chk("t4_m1_gnt0", {31'd0, m1_if.gnt}, 32'd0);
    cyc();
    m0_if.ren = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("t4_m1_blocked", {31'd0, m1_if.gnt}, 32'd0);
      chk("t4_s_wen_blocked", {31'd0, s_if.wen}, 32'd0);
      cyc();
    end
    man_rv = 1'b1; s_if.rdata = 32'hCAFE0001;
    settle();
    chk("t4_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
    chk("t4_m1_gnt_same", {31'd0, m1_if.gnt}, 32'd1);
    chk("t4_s_waddr", s_if.addr, 32'h300);
    cyc();
    m1_if.wen = 1'b0; man_rv = 1'b0;
    m0_if.wen = 1'b1; m0_if.addr = 32'h8;
    settle();
    chk("m0_wr_gnt", {31'd0, m0_if.gnt}, 32'd1);
    cyc();
    m0_if.wen = 1'b0;
    // wait state: selection must stay on m0 even though m1 would win a fresh conflict
    m0_if.ren = 1'b1; m0_if.addr = 32'h40; s_if.gnt = 1'b0;
    settle();
    chk("t3_raddr0", s_if.addr, 32'h40);
    chk("t3_m0_gnt0", {31'd0, m0_if.gnt}, 32'd0);
    cyc();
    m1_if.wen = 1'b1; m1_if.addr = 32'h80;
    settle();
    chk("t3_raddr1", s_if.addr, 32'h40);
    chk("t3_m1_gnt1", {31'd0, m1_if.gnt}, 32'd0);
    cyc();
    settle();
    chk("t3_raddr2", s_if.addr, 32'h40);
    cyc();
    s_if.gnt = 1'b1;
    settle();
    chk("t3_m0_gnt3", {31'd0, m0_if.gnt}, 32'd1);
    chk("t3_m1_gnt3", {31'd0, m1_if.gnt}, 32'd0);
    cyc();
    m0_if.ren = 1'b0; man_rv = 1'b1;
    settle();
    chk("t3_m1_gnt4", {31'd0, m1_if.gnt}, 32'd1);
    chk("t3_s_waddr4", s_if.addr, 32'h80);
    cyc();
    m1_if.wen = 1'b0; man_rv = 1'b0;
    // reset with a read pending
    m0_if.ren = 1'b1; m0_if.addr = 32'h10;
    settle();
    chk("t6_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    cyc();
    rst_n = 1'b0; m1_if.ren = 1'b1;
    settle();
    chk("t6_rst_s_ren", {31'd0, s_if.ren}, 32'd0);
    chk("t6_rst_gnt", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
    chk("t6_rst_perf", perf, 32'd0);
    cyc();
    rst_n = 1'b1; m0_if.ren = 1'b0; m1_if.ren = 1'b0; man_rv = 1'b1;
    settle();
    chk("t6_late_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    cyc();
    man_rv = 1'b0; m0_if.ren = 1'b1; m1_if.ren = 1'b1;
    settle();
    chk("t6_m1_first", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd2);
    cyc();
    m0_if.ren = 1'b0; m1_if.ren = 1'b0;
    settle();
    chk("t6_perf", perf, PERF ? 32'd1 : 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
